// File: rtl/data_mem_handler_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_handler_pkg : shared types and constants for the data-memory handler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package data_mem_handler_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int         BYTE_LANES = 4;
  localparam logic [3:0] SEL_WORD   = 4'hF;

  function automatic logic [3:0] byte_sel(input logic [1:0] b);
    return 4'b0001 << b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_mem_handler_if.sv
// ----------------------------------------------------------------------------
// data_mem_handler_if : handshaked data-bus between the handler and the memory
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface data_mem_handler_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_sel;
  logic              bus_read;
  logic              bus_write;
  logic              bus_busy;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_sel, bus_read, bus_write,
    input  bus_busy, bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_sel, bus_read, bus_write,
    output bus_busy, bus_rdata
  );
endinterface

`default_nettype wire

// File: rtl/data_mem_handler_byte_lane_unit.sv
// ----------------------------------------------------------------------------
// data_mem_handler_byte_lane_unit : store replication / byte enables, load
// byte extraction with sign extension. Purely combinational.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module data_mem_handler_byte_lane_unit
  import data_mem_handler_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              is_byte_i,
  input  logic [1:0]        offset_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [DATA_W-1:0] bus_rdata_i,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  output logic [DATA_W-1:0] load_data_o
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = 8'h00;
    case (offset_i)
      2'd0:    lane_byte = bus_rdata_i[7:0];
      2'd1:    lane_byte = bus_rdata_i[15:8];
      2'd2:    lane_byte = bus_rdata_i[23:16];
      default: lane_byte = bus_rdata_i[31:24];
    endcase
  end

  always_comb begin
    bus_sel_o   = SEL_WORD;
    bus_wdata_o = wdata_i;
    load_data_o = bus_rdata_i;
    if (is_byte_i) begin
      bus_sel_o   = byte_sel(offset_i);
      bus_wdata_o = {BYTE_LANES{wdata_i[7:0]}};
      load_data_o = {{(DATA_W-8){lane_byte[7]}}, lane_byte};
    end
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_handler.sv
// ----------------------------------------------------------------------------
// data_mem_handler : turns LB/LW/SB/SW into one handshaked bus transfer and
// stalls the core until it completes. Optional: MISALIGN_TRAP_EN.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module data_mem_handler
  import data_mem_handler_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic              load_byte,
  input  logic              store_byte,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              done,
  output logic              timeout,
  data_mem_handler_if.master bus
`ifdef MISALIGN_TRAP_EN
  ,
  output logic              misaligned
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  mem_state_t        state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic              is_write_q, is_write_d;
  logic              is_byte_q,  is_byte_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic              timeout_q,  timeout_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;

  logic              req;
  logic              req_byte;
  logic [3:0]        lane_sel;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] load_data;

  assign req      = read_mem | write_mem;
  assign req_byte = write_mem ? store_byte : load_byte;

`ifdef MISALIGN_TRAP_EN
  logic misal_q, misal_d;
  logic req_misal;
  assign req_misal  = ~req_byte & (addr[1:0] != 2'b00);
  assign misaligned = (state_q == DONE) & misal_q;
`endif

  data_mem_handler_byte_lane_unit #(
    .DATA_W (DATA_W)
  ) u_lane (
    .is_byte_i   (is_byte_q),
    .offset_i    (addr_q[1:0]),
    .wdata_i     (wdata_q),
    .bus_rdata_i (bus.bus_rdata),
    .bus_sel_o   (lane_sel),
    .bus_wdata_o (lane_wdata),
    .load_data_o (load_data)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      is_byte_q  <= 1'b0;
      rdata_q    <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
`ifdef MISALIGN_TRAP_EN
      misal_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      is_byte_q  <= is_byte_d;
      rdata_q    <= rdata_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
`ifdef MISALIGN_TRAP_EN
      misal_q    <= misal_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    is_write_d    = is_write_q;
    is_byte_d     = is_byte_q;
    rdata_d       = rdata_q;
    timeout_d     = timeout_q;
    cnt_d         = cnt_q;
`ifdef MISALIGN_TRAP_EN
    misal_d       = misal_q;
`endif
    stall         = 1'b0;
    done          = 1'b0;
    bus.bus_read  = 1'b0;
    bus.bus_write = 1'b0;
    bus.bus_sel   = 4'h0;
    bus.bus_wdata = '0;

    case (state_q)
      IDLE: begin
        if (req) begin
          stall      = 1'b1;
          addr_d     = addr;
          wdata_d    = wdata;
          is_write_d = write_mem;
          is_byte_d  = req_byte;
          timeout_d  = 1'b0;
          cnt_d      = '0;
          state_d    = REQ;
`ifdef MISALIGN_TRAP_EN
          misal_d    = 1'b0;
          if (req_misal) begin
            misal_d = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
`endif
        end
      end
      REQ: begin
        stall         = 1'b1;
        bus.bus_read  = ~is_write_q;
        bus.bus_write = is_write_q;
        bus.bus_sel   = lane_sel;
        bus.bus_wdata = lane_wdata;
        state_d       = WAIT;
      end
      WAIT: begin
        stall = 1'b1;
        // A release on the final counted cycle still completes normally.
        if (!bus.bus_busy) begin
          if (!is_write_q) begin
            rdata_d = load_data;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.bus_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign rdata        = rdata_q;
  assign timeout      = (state_q == DONE) & timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_data_mem_handler.sv
// ----------------------------------------------------------------------------
// tb_data_mem_handler : directed self-checking bench for data_mem_handler
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_data_mem_handler;

  logic        clk = 1'b0;
  logic        nRst;
  logic        read_mem, write_mem, load_byte, store_byte;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, done, timeout;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  data_mem_handler_if bus_if ();

  data_mem_handler dut (
    .clk        (clk),
    .nRst       (nRst),
    .read_mem   (read_mem),
    .write_mem  (write_mem),
    .load_byte  (load_byte),
    .store_byte (store_byte),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata),
    .stall      (stall),
    .done       (done),
    .timeout    (timeout),
    .bus        (bus_if.master)
`ifdef MISALIGN_TRAP_EN
    ,
    .misaligned (misaligned)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int          lat, nrd, nwr;
  logic [31:0] baddr, bwd, rd_out;
  logic [3:0]  bsel;
  logic        done_seen, to_seen, stall_ok, stall_done, done_after, mis_seen;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request, hold bus_busy for busy_n WAIT cycles, record what the bus saw.
  task automatic txn(input logic rd, input logic wr, input logic bt,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rbus, input int busy_n);
    int widx;
    widx = -1;
    nrd = 0; nwr = 0; baddr = 0; bsel = 0; bwd = 0; lat = 0; mis_seen = 1'b0;
    read_mem = rd; write_mem = wr; load_byte = bt; store_byte = bt;
    addr = a; wdata = wd;
    bus_if.bus_rdata = rbus;
    bus_if.bus_busy  = 1'b1;
    #1;
    stall_ok = stall;
    while (!done && lat < 400) begin
      tick();
      lat++;
      read_mem = 1'b0; write_mem = 1'b0;
      if (widx >= 0) begin
        bus_if.bus_busy = (widx < busy_n);
        widx++;
      end
      if (bus_if.bus_read || bus_if.bus_write) begin
        nrd   += int'(bus_if.bus_read);
        nwr   += int'(bus_if.bus_write);
        baddr = bus_if.bus_addr;
        bsel  = bus_if.bus_sel;
        bwd   = bus_if.bus_wdata;
        widx  = 0;
      end
      if (!done) stall_ok &= stall;
    end
    done_seen  = done;
    rd_out     = rdata;
    to_seen    = timeout;
    stall_done = stall;
`ifdef MISALIGN_TRAP_EN
    mis_seen   = misaligned;
`endif
    tick();
    done_after      = done;
    bus_if.bus_busy = 1'b0;
  endtask

  // Start a load, reset after n_ticks cycles, then watch that nothing completes.
  task automatic abort_test(input string tag, input int n_ticks);
    logic any_done;
    read_mem = 1'b1; load_byte = 1'b0; addr = 32'h600;
    bus_if.bus_busy = 1'b1;
    for (int i = 0; i < n_ticks; i++) begin
      tick();
      read_mem = 1'b0;
    end
    #2 nRst = 1'b0;
    #1;
    check({tag, "_stall"}, 32'(stall), 32'h0);
    check({tag, "_strobe"}, 32'({bus_if.bus_read, bus_if.bus_write}), 32'h0);
    nRst = 1'b1;
    any_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      any_done |= done | stall;
    end
    check({tag, "_quiet"}, 32'(any_done), 32'h0);
    bus_if.bus_busy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    nRst = 1'b0;
    read_mem = 1'b0; write_mem = 1'b0; load_byte = 1'b0; store_byte = 1'b0;
    addr = '0; wdata = '0;
    bus_if.bus_busy = 1'b0; bus_if.bus_rdata = '0;
    #3;
    check("rst_rdata", rdata, 32'h0);
    check("rst_ctl", 32'({stall, done, timeout, bus_if.bus_read, bus_if.bus_write, bus_if.bus_sel}), 32'h0);
    check("rst_addr", bus_if.bus_addr, 32'h0);
    check("rst_wdata", bus_if.bus_wdata, 32'h0);
    #4 nRst = 1'b1;
    tick(); tick();
    check("idle_ctl", 32'({stall, done, bus_if.bus_read, bus_if.bus_write}), 32'h0);

    // LW aligned, no busy
    txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    check("lw_lat", 32'(lat), 32'd3);
    check("lw_done", 32'(done_seen), 32'h1);
    check("lw_strobes", 32'({nrd[7:0], nwr[7:0]}), 32'h0100);
    check("lw_addr", baddr, 32'h100);
    check("lw_sel", 32'(bsel), 32'hF);
    check("lw_rdata", rd_out, 32'hDEADBEEF);
    check("lw_stall", 32'({stall_ok, stall_done}), 32'b10);
    check("lw_pulse", 32'({done_after, to_seen}), 32'h0);

    // LB sign extension, top lane negative
    txn(1'b1, 1'b0, 1'b1, 32'h103, 32'h0, 32'h80000000, 0);
    check("lb3_rdata", rd_out, 32'hFFFFFF80);
    check("lb3_sel", 32'(bsel), 32'h8);
    check("lb3_addr", baddr, 32'h100);
    txn(1'b1, 1'b0, 1'b1, 32'h101, 32'h0, 32'h00007F00, 0);
    check("lb1_rdata", rd_out, 32'h0000007F);
    check("lb1_sel", 32'(bsel), 32'h2);

    // SB replication
    txn(1'b0, 1'b1, 1'b1, 32'h202, 32'h123456AB, 32'h0, 0);
    check("sb_sel", 32'(bsel), 32'h4);
    check("sb_wdata", bwd, 32'hABABABAB);
    check("sb_addr", baddr, 32'h200);
    check("sb_strobes", 32'({nrd[7:0], nwr[7:0]}), 32'h0001);
    check("sb_rdata_held", rd_out, 32'h0000007F);

    // SW with five busy cycles
    txn(1'b0, 1'b1, 1'b0, 32'h300, 32'hCAFEF00D, 32'h0, 5);
    check("sw_lat", 32'(lat), 32'd8);
    check("sw_stall", 32'(stall_ok), 32'h1);
    check("sw_wdata", bwd, 32'hCAFEF00D);
    check("sw_sel", 32'(bsel), 32'hF);

    // Busy stuck high: forced completion after 255 WAIT cycles
    txn(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 32'h12345678, 1000);
    check("to_lat", 32'(lat), 32'd257);
    check("to_flag", 32'({done_seen, to_seen}), 32'b11);
    check("to_rdata", rd_out, 32'h0);
    check("to_stall", 32'(stall_ok), 32'h1);

    // Read and write together: write wins
    txn(1'b1, 1'b1, 1'b0, 32'h500, 32'h55AA55AA, 32'hFFFFFFFF, 0);
    check("rw_strobes", 32'({nrd[7:0], nwr[7:0]}), 32'h0001);
    check("rw_wdata", bwd, 32'h55AA55AA);
    check("rw_timeout", 32'(to_seen), 32'h0);

    // Misaligned word accesses
    txn(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 32'h11223344, 0);
`ifdef MISALIGN_TRAP_EN
    check("mlw_lat", 32'(lat), 32'd1);
    check("mlw_strobes", 32'({nrd[7:0], nwr[7:0]}), 32'h0);
    check("mlw_flag", 32'({done_seen, mis_seen}), 32'b11);
    check("mlw_rdata", rd_out, 32'h0);
`else
    check("mlw_lat", 32'(lat), 32'd3);
    check("mlw_addr", baddr, 32'h100);
    check("mlw_sel", 32'(bsel), 32'hF);
    check("mlw_rdata", rd_out, 32'h11223344);
`endif
    txn(1'b0, 1'b1, 1'b0, 32'h306, 32'h0BADF00D, 32'h0, 0);
`ifdef MISALIGN_TRAP_EN
    check("msw_strobes", 32'({nrd[7:0], nwr[7:0]}), 32'h0);
    check("msw_flag", 32'(mis_seen), 32'h1);
`else
    check("msw_strobes", 32'({nrd[7:0], nwr[7:0]}), 32'h0001);
    check("msw_addr", baddr, 32'h304);
`endif

    // Reset mid-transaction
    abort_test("abort_req", 1);
    abort_test("abort_wait", 3);

    // Normal operation after abort
    txn(1'b1, 1'b0, 1'b1, 32'h700, 32'h0, 32'h000000C3, 0);
    check("post_rdata", rd_out, 32'hFFFFFFC3);
    check("post_lat", 32'(lat), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
